// File: rtl/msg_pkg.sv
// Shared constants, state encoding and helpers for the ASCII line streamer.
// Imported by the character encoder and the streamer top.
package msg_pkg;

  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_1  = 8'h31;
  localparam logic [7:0] ASC_A  = 8'h41;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE,
    DIGITS,
    EOL_LF,
    EOL_CR
  } state_e;

  // Uppercase hex digit for a nibble.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return ASC_0 + {4'h0, nib};
    end
    return ASC_A + {4'h0, nib} - 8'd10;
  endfunction

  function automatic int hex_digits(input int width);
    return (width + 3) / 4;
  endfunction

endpackage

// File: rtl/msg_char_encode.sv
// Combinational digit renderer: picks the bit or nibble addressed by index_i
// (index 0 is the most significant digit) and returns its ASCII character.
module msg_char_encode
  import msg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IW    = 4
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic             hex_mode_i,
  input  logic [IW-1:0]    index_i,
  output logic [7:0]       char_o
);

  localparam int HD = hex_digits(WIDTH);

  logic [4*HD-1:0] padded;
  logic            bitSel;
  logic [3:0]      nibSel;
  int              binPos;
  int              hexPos;

  assign binPos = WIDTH - 1 - int'(index_i);
  assign hexPos = HD - 1 - int'(index_i);

  // Constant-index scans keep the selects in range for every WIDTH.
  always_comb begin
    padded = '0;
    padded[WIDTH-1:0] = word_i;
    bitSel = 1'b0;
    nibSel = 4'h0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == binPos) bitSel = word_i[i];
    end
    for (int n = 0; n < HD; n++) begin
      if (n == hexPos) nibSel = padded[4*n +: 4];
    end
    if (hex_mode_i) begin
      char_o = nibble_to_ascii(nibSel);
    end else begin
      char_o = bitSel ? ASC_1 : ASC_0;
    end
  end

endmodule

// File: rtl/msg_line_streamer.sv
// Captures a word on load and streams it as binary/hex ASCII digits plus an
// optional LF/CR, one character per valid/ready handshake, with a one-deep pending slot.
module msg_line_streamer
  import msg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit EOL   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] bits_in,
  input  logic             hex_mode,
  output logic             char_valid,
  output logic [7:0]       char_data,
  input  logic             char_ready,
  output logic             busy,
  output logic             overflow
);

  localparam int            IW       = $clog2(WIDTH) + 1;
  localparam int            HD       = hex_digits(WIDTH);
  localparam logic [IW-1:0] BIN_LAST = IW'(WIDTH - 1);
  localparam logic [IW-1:0] HEX_LAST = IW'(HD - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] actWord_q, actWord_d;
  logic             actHex_q, actHex_d;
  logic [WIDTH-1:0] pendWord_q, pendWord_d;
  logic             pendHex_q, pendHex_d;
  logic             pendValid_q, pendValid_d;
  logic             overflow_q, overflow_d;
  logic             charValid_q, charValid_d;
  logic [7:0]       charData_q, charData_d;
  logic [7:0]       encChar;
  logic [IW-1:0]    lastIdx;
  logic             xfer;
  logic             msgDone;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      actWord_q   <= '0;
      actHex_q    <= 1'b0;
      pendWord_q  <= '0;
      pendHex_q   <= 1'b0;
      pendValid_q <= 1'b0;
      overflow_q  <= 1'b0;
      charValid_q <= 1'b0;
      charData_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      actWord_q   <= actWord_d;
      actHex_q    <= actHex_d;
      pendWord_q  <= pendWord_d;
      pendHex_q   <= pendHex_d;
      pendValid_q <= pendValid_d;
      overflow_q  <= overflow_d;
      charValid_q <= charValid_d;
      charData_q  <= charData_d;
    end
  end

  // The encoder looks at next-state values so char_data is registered yet
  // already shows the first digit in the cycle right after acceptance.
  msg_char_encode #(
    .WIDTH(WIDTH),
    .IW   (IW)
  ) u_encode (
    .word_i    (actWord_d),
    .hex_mode_i(actHex_d),
    .index_i   (idx_d),
    .char_o    (encChar)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    actWord_d   = actWord_q;
    actHex_d    = actHex_q;
    pendWord_d  = pendWord_q;
    pendHex_d   = pendHex_q;
    pendValid_d = pendValid_q;
    overflow_d  = overflow_q;
    msgDone     = 1'b0;
    xfer        = charValid_q & char_ready;
    lastIdx     = actHex_q ? HEX_LAST : BIN_LAST;

    case (state_q)
      IDLE: begin
        if (load) begin
          state_d   = DIGITS;
          idx_d     = '0;
          actWord_d = bits_in;
          actHex_d  = hex_mode;
        end
      end
      DIGITS: begin
        if (xfer) begin
          if (idx_q == lastIdx) begin
            if (EOL) state_d = EOL_LF;
            else     msgDone = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      EOL_LF: begin
        if (xfer) state_d = EOL_CR;
      end
      EOL_CR: begin
        if (xfer) msgDone = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A finishing message frees the pending slot in the same cycle, so a
    // coincident load refills it instead of overflowing.
    if (msgDone) begin
      idx_d = '0;
      if (pendValid_q) begin
        state_d     = DIGITS;
        actWord_d   = pendWord_q;
        actHex_d    = pendHex_q;
        pendValid_d = load;
        if (load) begin
          pendWord_d = bits_in;
          pendHex_d  = hex_mode;
        end
      end else if (load) begin
        state_d   = DIGITS;
        actWord_d = bits_in;
        actHex_d  = hex_mode;
      end else begin
        state_d = IDLE;
      end
    end else if (state_q != IDLE && load) begin
      if (!pendValid_q) begin
        pendValid_d = 1'b1;
        pendWord_d  = bits_in;
        pendHex_d   = hex_mode;
      end else begin
        overflow_d = 1'b1;
      end
    end

    charValid_d = (state_d != IDLE);
    case (state_d)
      DIGITS:  charData_d = encChar;
      EOL_LF:  charData_d = ASC_LF;
      EOL_CR:  charData_d = ASC_CR;
      default: charData_d = 8'h00;
    endcase
  end

  assign char_valid = charValid_q;
  assign char_data  = charData_q;
  assign busy       = charValid_q | pendValid_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_msg_line_streamer.sv
// Scoreboard bench for msg_line_streamer: three instances (WIDTH 8/12/5, EOL on),
// directed loads push hand-computed characters, a negedge monitor pops and compares.
module tb_msg_line_streamer;

  typedef struct {
    int         dut;
    logic [7:0] ch;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       load;
  logic [2:0]       hexMode;
  logic [2:0]       rdy;
  logic [2:0]       cv;
  logic [2:0]       busy;
  logic [2:0]       ovf;
  logic [2:0][7:0]  cd;
  logic [7:0]       bits8;
  logic [11:0]      bits12;
  logic [4:0]       bits5;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   firstV     = -1;
  int   lastV      = -1;
  int   xferCount  = 0;

  always #5 clk = ~clk;

  msg_line_streamer #(.WIDTH(8), .EOL(1'b1)) u8 (
    .clk(clk), .rst(rst), .load(load[0]), .bits_in(bits8), .hex_mode(hexMode[0]),
    .char_valid(cv[0]), .char_data(cd[0]), .char_ready(rdy[0]),
    .busy(busy[0]), .overflow(ovf[0])
  );

  msg_line_streamer #(.WIDTH(12), .EOL(1'b1)) u12 (
    .clk(clk), .rst(rst), .load(load[1]), .bits_in(bits12), .hex_mode(hexMode[1]),
    .char_valid(cv[1]), .char_data(cd[1]), .char_ready(rdy[1]),
    .busy(busy[1]), .overflow(ovf[1])
  );

  msg_line_streamer #(.WIDTH(5), .EOL(1'b1)) u5 (
    .clk(clk), .rst(rst), .load(load[2]), .bits_in(bits5), .hex_mode(hexMode[2]),
    .char_valid(cv[2]), .char_data(cd[2]), .char_ready(rdy[2]),
    .busy(busy[2]), .overflow(ovf[2])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds load for one cycle; returns 1ns after the capturing edge.
  task automatic applyStimulus(input int d, input logic [31:0] word, input logic hex);
    case (d)
      0:       bits8  = word[7:0];
      1:       bits12 = word[11:0];
      default: bits5  = word[4:0];
    endcase
    hexMode[d] = hex;
    load[d]    = 1'b1;
    tick();
    load[d]    = 1'b0;
  endtask

  task automatic pushChars(input int d, input string s, input bit eol);
    exp_t e;
    e.dut = d;
    for (int i = 0; i < s.len(); i++) begin
      e.ch = s[i];
      expQ.push_back(e);
    end
    if (eol) begin
      e.ch = 8'h0A;
      expQ.push_back(e);
      e.ch = 8'h0D;
      expQ.push_back(e);
    end
  endtask

  task automatic waitIdle(input int d, input int budget, input bit toggle);
    int n;
    n = 0;
    while ((busy[d] || expQ.size() != 0) && n < budget) begin
      tick();
      if (toggle) rdy[d] = ~rdy[d];
      n++;
    end
    rdy[d] = 1'b1;
    if (n >= budget) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: dut %0d still busy after %0d cycles, required idle", d, budget);
    end
    checkOutput("idle_busy", busy[d], 0);
    checkOutput("idle_valid", cv[d], 0);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  initial begin : monitor
    logic [2:0]      prevStall;
    logic [2:0][7:0] prevData;
    exp_t            e;
    prevStall = '0;
    prevData  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 3; d++) begin
        if (rst) begin
          prevStall[d] = 1'b0;
        end else begin
          if (prevStall[d]) begin
            checkOutput("stall_valid", cv[d], 1);
            checkOutput("stall_data", cd[d], prevData[d]);
          end
          if (cv[d]) begin
            if (firstV < 0) firstV = cyc;
            lastV = cyc;
          end
          if (cv[d] && rdy[d]) begin
            xferCount++;
            if (expQ.size() == 0) begin
              compared++;
              mismatched++;
              $display("[TB] FAIL unexpected_char: dut %0d emitted 0x%0h, required none", d, cd[d]);
            end else begin
              e = expQ.pop_front();
              checkOutput("char_dut", d, e.dut);
              checkOutput("char_data", cd[d], e.ch);
            end
          end
          prevStall[d] = cv[d] && !rdy[d];
          prevData[d]  = cd[d];
        end
      end
    end
  end

  initial begin
    rst     = 1'b1;
    load    = '0;
    hexMode = '0;
    rdy     = 3'b111;
    bits8   = '0;
    bits12  = '0;
    bits5   = '0;
    #2;
    checkOutput("reset_valid", cv[0], 0);
    checkOutput("reset_data", cd[0], 8'h00);
    checkOutput("reset_busy", busy[0], 0);
    checkOutput("reset_overflow", ovf[0], 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Binary 8'hA5, first digit right after the capturing edge.
    pushChars(0, "10100101", 1'b1);
    xferCount = 0;
    applyStimulus(0, 32'hA5, 1'b0);
    checkOutput("latency_valid", cv[0], 1);
    checkOutput("latency_busy", busy[0], 1);
    checkOutput("latency_data", cd[0], 8'h31);
    waitIdle(0, 40, 1'b0);
    checkOutput("a5_transfers", xferCount, 10);

    // Hex widths that need zero-padding or exact nibbles.
    pushChars(1, "0F3", 1'b1);
    applyStimulus(1, 32'h0F3, 1'b1);
    waitIdle(1, 40, 1'b0);
    pushChars(2, "1B", 1'b1);
    applyStimulus(2, 32'h1B, 1'b1);
    waitIdle(2, 40, 1'b0);
    pushChars(2, "10011", 1'b1);
    applyStimulus(2, 32'h13, 1'b0);
    waitIdle(2, 40, 1'b0);

    // Backpressure: ready alternates, output sequence unchanged.
    pushChars(0, "00111100", 1'b1);
    xferCount = 0;
    applyStimulus(0, 32'h3C, 1'b0);
    waitIdle(0, 60, 1'b1);
    checkOutput("bp_transfers", xferCount, 10);

    // Pending slot fills, third load overflows and is dropped.
    pushChars(0, "00000001", 1'b1);
    pushChars(0, "00000010", 1'b1);
    xferCount = 0;
    firstV    = -1;
    applyStimulus(0, 32'h01, 1'b0);
    tick();
    applyStimulus(0, 32'h02, 1'b0);
    checkOutput("pend_overflow_clear", ovf[0], 0);
    tick();
    applyStimulus(0, 32'h03, 1'b0);
    checkOutput("overflow_set", ovf[0], 1);
    waitIdle(0, 60, 1'b0);
    checkOutput("b2b_transfers", xferCount, 20);
    checkOutput("b2b_span", lastV - firstV + 1, 20);
    checkOutput("overflow_sticky", ovf[0], 1);

    // Asynchronous reset during the 4th digit.
    pushChars(0, "101", 1'b0);
    applyStimulus(0, 32'hA5, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_valid", cv[0], 0);
    checkOutput("rst_mid_busy", busy[0], 0);
    checkOutput("rst_mid_overflow", ovf[0], 0);
    checkOutput("rst_mid_queue", expQ.size(), 0);
    #2;
    rst = 1'b0;
    tick();
    pushChars(0, "10100101", 1'b1);
    applyStimulus(0, 32'hA5, 1'b0);
    checkOutput("post_rst_first", cd[0], 8'h31);
    waitIdle(0, 40, 1'b0);

    // Load coincides with the final CR while pending is full.
    pushChars(0, "00010001", 1'b1);
    pushChars(0, "00100010", 1'b1);
    pushChars(0, "00110011", 1'b1);
    xferCount = 0;
    firstV    = -1;
    applyStimulus(0, 32'h11, 1'b0);
    tick();
    applyStimulus(0, 32'h22, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    applyStimulus(0, 32'h33, 1'b0);
    checkOutput("coincide_overflow", ovf[0], 0);
    waitIdle(0, 80, 1'b0);
    checkOutput("coincide_transfers", xferCount, 30);
    checkOutput("coincide_span", lastV - firstV + 1, 30);
    checkOutput("coincide_overflow_end", ovf[0], 0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/msg_line_streamer.md
# msg_line_streamer

Parametrised successor to the fixed 8-bit message ROM. Captures a WIDTH-bit word on a load strobe and streams it as ASCII characters (binary or hex digits, MSB first), optionally followed by "\n" "\r", one character per handshake. Sits between the keyboard/bit source and the message printer / UART transmitter. Holds one word in flight plus a one-deep pending slot, so loads arriving mid-message are not lost.

## Interface

Parameters:
- WIDTH, 8: input word width, legal 1..32.
- EOL, 1: 1 = append 0x0A then 0x0D after the digits; 0 = digits only.

Ports:
- clk  in  1  system clock; single clock domain, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  capture request for bits_in/hex_mode this cycle.
- bits_in  in  WIDTH  word to render.
- hex_mode  in  1  0 = binary digits, 1 = hex digits; sampled with load.
- char_valid  out  1  char_data holds a character.
- char_data  out  8  ASCII character.
- char_ready  in  1  sink accepts char_data when char_valid is also high.
- busy  out  1  char_valid | pending_valid.
- overflow  out  1  sticky: a load was dropped; cleared only by rst.

## Operation

- Message length: binary mode = WIDTH digits, each "0" (0x30) or "1" (0x31); hex mode = ceil(WIDTH/4) digits, 0-9 -> 0x30-0x39, A-F uppercase 0x41-0x46, top nibble zero-padded. Then 2 EOL chars if EOL=1.
- Digit order: MSB (bit/nibble) first.
- FSM states: IDLE, DIGITS, EOL_LF, EOL_CR.
  - IDLE -> DIGITS on load (or pending promotion).
  - DIGITS: index counts 0..N-1; a transfer at N-1 goes -> EOL_LF (EOL=1), or ends the message (EOL=0).
  - EOL_LF -> EOL_CR on transfer.
  - EOL_CR: a transfer ends the message.
  - End of message: go to DIGITS with the pending word if one is present, else IDLE.
- Word and hex_mode are latched into the active register at acceptance. Changes on bits_in/hex_mode afterwards have no effect.
- Load while active and pending empty: word stored in pending slot.
- Load while active and pending full: new word dropped, overflow set. Exception: the same cycle completes the message, so pending promotes and the new word takes the pending slot with no overflow.
- Load while IDLE: word goes straight to active.
- Load in the same cycle as the final transfer with pending empty: word becomes the next active message.

## Timing

- Reset values: char_valid 0, char_data 0x00, busy 0, overflow 0, state IDLE, pending slot empty. Reset mid-message discards both words immediately (asynchronous).
- Latency: load at edge k (IDLE) -> char_valid=1 with the first digit after edge k; busy high the same cycle.
- char_data and char_valid are registered outputs.
- While char_valid=1 and char_ready=0, char_data is held stable and char_valid stays high.
- A transfer occurs on an edge with char_valid & char_ready. The next character appears after that edge, so throughput is 1 char/cycle with char_ready held high.
- Back-to-back messages: the first digit of the promoted word follows the final CR (or last digit) with no idle cycle.
- A message of N chars with char_ready held high: char_valid high exactly N cycles.
- Index counter width is clog2(WIDTH) + 1. The counter wraps to 0 at each message start.

## Structure

- Package msg_pkg holds:
  - ASCII constants: ASC_0, ASC_1, ASC_A, ASC_LF, ASC_CR.
  - The state enum.
  - function nibble_to_ascii.
  - function hex_digits(width) = (width+3)/4.
- Sub-module msg_char_encode: combinational. Takes (word, hex_mode, index) and returns the digit character. Instantiated once; its output feeds the char_data register.

## Test plan

- WIDTH=8, EOL=1, binary, load 8'hA5, char_ready=1 -> chars "10100101" 0x0A 0x0D on 10 consecutive cycles; busy falls after the last one.
- WIDTH=12, hex, load 12'h0F3 -> "0","F","3",0x0A,0x0D. WIDTH=5, hex, load 5'h1B -> "1","B",LF,CR.
- Backpressure: char_ready toggled 1010... during 8'h3C -> char_data stable through every ready=0 cycle; output sequence unchanged, 10 transfers.
- Load 8'h01 then 8'h02 mid-message, then 8'h03 while pending full -> messages "00000001"LFCR then "00000010"LFCR, no gap between them; overflow=1; 8'h03 never emitted.
- Load coinciding with the final CR transfer while pending full -> no overflow; the three messages are emitted in order.
- Assert rst during the 4th digit -> char_valid, busy and overflow 0 immediately. A load after release starts a fresh message from the first digit.
